// File: rtl/ddr_read_channel_arbiter.sv
// ddr_read_channel_arbiter: shares one DDR read port among CH_NUM camera
// channels, one fixed-length burst per grant, round-robin or manual select.
// Build option: define ARB_TIMEOUT_EN to build the inter-beat watchdog;
// without it timeout_err is tied low and a grant waits for all beats.
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   ch_req            per-channel level request
//   manual_mode       1 = only manual_sel is eligible
//   manual_sel        channel index from the key bank switch
//   rd_beat           read master consumed one beat of the burst
//   grant_valid       high for the whole grant
//   grant_ch          granted channel, meaningful while grant_valid
//   burst_done        one-cycle pulse when the grant ends
//   timeout_err       one-cycle pulse when the watchdog aborts a grant
//   busy              FSM is in GRANT or DONE
module ddr_read_channel_arbiter #(
    parameter int CH_NUM    = 4,
    parameter int BURST_LEN = 256,
    parameter int TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CH_NUM-1:0] ch_req,
    input  logic              manual_mode,
    input  logic [3:0]        manual_sel,
    input  logic              rd_beat,
    output logic              grant_valid,
    output logic [3:0]        grant_ch,
    output logic              burst_done,
    output logic              timeout_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [3:0]       PTR_RST   = 4'(CH_NUM - 1);

    if (CH_NUM < 1 || CH_NUM > 16 || BURST_LEN < 2 || TIMEOUT < 1)
    begin : g_bad_cfg
        $error("ddr_read_channel_arbiter: invalid parameters");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE
    } state_t;

    state_t            state;
    logic [3:0]        ptr;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CH_NUM-1:0] elig;
    logic [3:0]        pick;
    logic              found;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    // Abort on the idle cycle that brings the count to TIMEOUT.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            to_err_q;

    assign timeout_err = to_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // A manual_sel outside the channel range matches no bit, so nothing
    // is eligible.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            elig[i] = ch_req[i] & (~manual_mode | (manual_sel == 4'(i)));
        end
    end

    // First eligible channel searching upward from ptr+1, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            if (!found && elig[(int'(ptr) + k) % CH_NUM]) begin
                found = 1'b1;
                pick  = 4'((int'(ptr) + k) % CH_NUM);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_ch    <= '0;
            burst_done  <= 1'b0;
            busy        <= 1'b0;
            beat_cnt    <= '0;
            ptr         <= PTR_RST;
`ifdef ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            to_err_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state       <= GRANT;
                        grant_valid <= 1'b1;
                        grant_ch    <= pick;
                        busy        <= 1'b1;
                    end
                end
                GRANT: begin
                    if (rd_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
`ifdef ARB_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                        if (beat_cnt == LAST_BEAT) begin
                            state       <= DONE;
                            grant_valid <= 1'b0;
                            burst_done  <= 1'b1;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        state       <= DONE;
                        grant_valid <= 1'b0;
                        burst_done  <= 1'b1;
                        to_err_q    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state      <= IDLE;
                    burst_done <= 1'b0;
                    busy       <= 1'b0;
                    ptr        <= grant_ch;
                    beat_cnt   <= '0;
`ifdef ARB_TIMEOUT_EN
                    wd_cnt     <= '0;
                    to_err_q   <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_read_channel_arbiter.sv
// tb_ddr_read_channel_arbiter: directed scoreboard bench for the DDR read
// channel arbiter (4 channels, 256-beat bursts, TIMEOUT = 100).
module tb_ddr_read_channel_arbiter;

    localparam int CH_NUM = 4;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN     = 1'b1;
    localparam int STALL_LEN = 110;
`else
    localparam bit TO_EN     = 1'b0;
    localparam int STALL_LEN = 406;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic [CH_NUM-1:0] ch_req;
    logic              manual_mode;
    logic [3:0]        manual_sel;
    logic              rd_beat;
    logic              grant_valid;
    logic [3:0]        grant_ch;
    logic              burst_done;
    logic              timeout_err;
    logic              busy;

    ddr_read_channel_arbiter #(
        .CH_NUM   (CH_NUM),
        .BURST_LEN(256),
        .TIMEOUT  (100)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ch_req     (ch_req),
        .manual_mode(manual_mode),
        .manual_sel (manual_sel),
        .rd_beat    (rd_beat),
        .grant_valid(grant_valid),
        .grant_ch   (grant_ch),
        .burst_done (burst_done),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ch;
        int         len;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int n_tests  = 0;
    int n_fail   = 0;
    int nstarts  = 0;
    int ngrants  = 0;
    int n_done   = 0;
    int n_to     = 0;
    int busy_bad = 0;
    int len      = 0;
    int low_cnt  = 0;
    bit prev_gv  = 1'b0;
    bit have_fall = 1'b0;
    bit gap_chk  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] ch, input int l, input logic to);
        exp_t e;
        e.ch  = ch;
        e.len = l;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    task automatic wait_starts(input int n);
        int k = 0;
        while (nstarts < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_start", 32'(nstarts >= n), 1);
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (ngrants < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_grant_end", 32'(ngrants >= n), 1);
    endtask

    task automatic wait_gv();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!grant_valid && k < 100);
        chk("wait_gv", 32'(grant_valid), 1);
    endtask

    // Monitor: pops the scoreboard on each grant start and checks channel,
    // grant length, end-of-grant pulses and the inter-grant gap.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_gv   = 1'b0;
            have_fall = 1'b0;
        end else begin
            if (busy !== (grant_valid | burst_done)) busy_bad++;
            if (burst_done) n_done++;
            if (timeout_err) n_to++;
            if (grant_valid && !prev_gv) begin
                nstarts++;
                chk("sb_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("grant_ch", grant_ch, cur.ch);
                end
                if (gap_chk && have_fall) chk("grant_gap", low_cnt, 2);
                len = 0;
            end
            if (grant_valid) len++;
            if (!grant_valid && prev_gv) begin
                chk("grant_len", len, cur.len);
                chk("done_at_end", burst_done, 1);
                chk("to_at_end", timeout_err, cur.to);
                ngrants++;
                have_fall = 1'b1;
                low_cnt   = 0;
            end
            if (!grant_valid) low_cnt++;
            prev_gv = grant_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        int done_snap;
        rstn        = 1'b0;
        ch_req      = '0;
        manual_mode = 1'b0;
        manual_sel  = 4'd0;
        rd_beat     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_ch", grant_ch, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);

        // Automatic round robin over all four channels.
        gap_chk = 1'b1;
        push(4'd0, 256, 1'b0);
        push(4'd1, 256, 1'b0);
        push(4'd2, 256, 1'b0);
        push(4'd3, 256, 1'b0);
        push(4'd0, 256, 1'b0);
        rd_beat = 1'b1;
        ch_req  = 4'b1111;
        wait_starts(5);
        ch_req = '0;
        wait_grants(5);
        gap_chk = 1'b0;

        // Sparse requests: 0 and 2 must never be granted.
        push(4'd1, 256, 1'b0);
        push(4'd3, 256, 1'b0);
        push(4'd1, 256, 1'b0);
        ch_req = 4'b1010;
        wait_starts(8);
        ch_req = '0;
        wait_grants(8);

        // Manual lock on channel 2, then an out-of-range selection.
        push(4'd2, 256, 1'b0);
        push(4'd2, 256, 1'b0);
        push(4'd2, 256, 1'b0);
        manual_mode = 1'b1;
        manual_sel  = 4'd2;
        ch_req      = 4'b1111;
        wait_starts(11);
        manual_sel = 4'd7;
        wait_grants(11);
        k = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || grant_valid) k++;
        end
        chk("manual_oor_busy", k, 0);

        // Selection change mid-burst does not cut the current burst.
        push(4'd0, 256, 1'b0);
        push(4'd1, 256, 1'b0);
        manual_sel = 4'd0;
        wait_starts(12);
        repeat (50) @(negedge clk);
        manual_sel = 4'd1;
        wait_starts(13);
        ch_req      = '0;
        manual_mode = 1'b0;
        wait_grants(13);

        // Beats stop after beat 10 of a grant to channel 2.
        rd_beat = 1'b0;
        push(4'd2, STALL_LEN, TO_EN);
        ch_req = 4'b0100;
        wait_gv();
        ch_req  = '0;
        rd_beat = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rd_beat = 1'b0;
`ifdef ARB_TIMEOUT_EN
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!timeout_err && k < 200);
        chk("timeout_lat", k + 1, 101);
        chk("timeout_done", burst_done, 1);
        chk("timeout_gv", grant_valid, 0);
`else
        repeat (150) @(negedge clk);
        chk("stall_gv_held", grant_valid, 1);
        chk("stall_no_err", n_to, 0);
        rd_beat = 1'b1;
`endif
        wait_grants(14);

        // Pointer must now sit on channel 2: 0101 grants channel 0 next.
        rd_beat = 1'b1;
        push(4'd0, 256, 1'b0);
        ch_req = 4'b0101;
        wait_gv();
        ch_req = '0;
        wait_grants(15);

        // Reset at beat 100, then the lowest requester wins.
        push(4'd1, 256, 1'b0);
        ch_req = 4'b1010;
        wait_gv();
        done_snap = n_done;
        repeat (100) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_grant_valid", grant_valid, 0);
        chk("midrst_grant_ch", grant_ch, 0);
        chk("midrst_burst_done", burst_done, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        chk("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("midrst_no_done", n_done, done_snap);
        push(4'd1, 256, 1'b0);
        @(posedge clk);
        #2 rstn = 1'b1;
        wait_gv();
        ch_req = '0;
        wait_grants(16);
        repeat (5) @(negedge clk);

        chk("sb_empty", exp_q.size(), 0);
        chk("done_count", n_done, ngrants);
        chk("to_count", n_to, 32'(TO_EN));
        chk("busy_consistency", busy_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
